// File: rtl/jk_input_conditioner.sv
// Input conditioning for the board-level JK flip-flop: synchronise and debounce J/K,
// generate the divided timebase tick, and present J/K snapshots that are stable around each tick.
module jk_input_conditioner #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 200000,
   parameter int unsigned TICK_DIV        = 20000001
) (
   input  logic clk,
   input  logic rst,
   input  logic j_raw,
   input  logic k_raw,
   output logic j_clean,
   output logic k_clean,
   output logic j_chg,
   output logic k_chg,
   output logic j_hold,
   output logic k_hold,
   output logic tick
);

   localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned TW  = $clog2(TICK_DIV);
   localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [TW-1:0]  HOLD_LOAD = TW'(TICK_DIV - 2);

   // Channel index 0 is J, 1 is K.
   logic [1:0]             raw;
   logic [1:0]             s;
   logic [SYNC_STAGES-1:0] sync_q [2];
   logic [DBW-1:0]         db_q   [2];
   logic [DBW-1:0]         db_d   [2];
   logic [1:0]             clean_q, clean_d;
   logic [1:0]             dly_q;
   logic [1:0]             chg_q;
   logic [1:0]             hold_q, hold_d;
   logic [TW-1:0]          tcnt_q, tcnt_d;
   logic                   tick_q, tick_d;

   assign raw  = {k_raw, j_raw};
   assign s[0] = sync_q[0][SYNC_STAGES-1];
   assign s[1] = sync_q[1][SYNC_STAGES-1];

   // PENDING is simply s != clean; the counter only runs while that holds.
   always_comb begin
      for (int unsigned c = 0; c < 2; c++) begin
         clean_d[c] = clean_q[c];
         db_d[c]    = '0;
         if (s[c] != clean_q[c]) begin
            if (db_q[c] == DB_LAST) begin
               clean_d[c] = ~clean_q[c];
            end else begin
               db_d[c] = db_q[c] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      tcnt_d = (tcnt_q == TICK_LAST) ? '0 : tcnt_q + 1'b1;
      tick_d = (tcnt_q == TICK_LAST);
      hold_d = (tcnt_q == HOLD_LOAD) ? clean_q : hold_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned c = 0; c < 2; c++) begin
            sync_q[c] <= '0;
            db_q[c]   <= '0;
         end
         clean_q <= '0;
         dly_q   <= '0;
         chg_q   <= '0;
         hold_q  <= '0;
         tcnt_q  <= '0;
         tick_q  <= 1'b0;
      end else begin
         for (int unsigned c = 0; c < 2; c++) begin
            sync_q[c] <= {sync_q[c][SYNC_STAGES-2:0], raw[c]};
            db_q[c]   <= db_d[c];
         end
         clean_q <= clean_d;
         dly_q   <= clean_q;
         chg_q   <= clean_q ^ dly_q;
         hold_q  <= hold_d;
         tcnt_q  <= tcnt_d;
         tick_q  <= tick_d;
      end
   end

   assign j_clean = clean_q[0];
   assign k_clean = clean_q[1];
   assign j_chg   = chg_q[0];
   assign k_chg   = chg_q[1];
   assign j_hold  = hold_q[0];
   assign k_hold  = hold_q[1];
   assign tick    = tick_q;

endmodule
